// File: rtl/lsu_op_arb.sv
// lsu_op_arb
//   Two-requester arbiter and SETUP/ACCESS sequencer for the output-peripheral
//   bank (HEX0-7, LEDR, LEDG, LCD registers). Requester 0 is the core LSU,
//   requester 1 a secondary master (debug/boot loader). Each granted request
//   becomes one SETUP cycle, one ACCESS cycle, then a one-cycle ack carrying
//   registered read data.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   rN_req_i                request, held until rN_ack_o
//   rN_addr_i / rN_write_i  word address, 1 = store
//   rN_wdata_i / rN_funct_i store data, funct3 size/sign code
//   rN_ack_o / rN_rdata_o   completion pulse, load data (0 for stores)
//   paddr_o, pwrite_o, pwdata_o, pfunct_code_o, penable_o   bank port
//   prdata_i                bank read data, valid while penable_o is high
//   busy_o                  high in SETUP and ACCESS
//
// Build option
//   OPB_ARB_RR_EN  defined: round-robin on ties (last-owner register built)
//                  undefined: fixed priority, r0 wins every tie
//
// state  | meaning
// IDLE   | no bank activity; grants the next eligible request
// SETUP  | latched addr/funct/write/wdata driven, penable_o = 0
// ACCESS | penable_o = 1; bank commits store, read data captured on exit

module lsu_op_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              r0_req_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic              r0_write_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  input  logic [2:0]        r0_funct_i,
  output logic              r0_ack_o,
  output logic [DATA_W-1:0] r0_rdata_o,

  input  logic              r1_req_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic              r1_write_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  input  logic [2:0]        r1_funct_i,
  output logic              r1_ack_o,
  output logic [DATA_W-1:0] r1_rdata_o,

  output logic [ADDR_W-1:0] paddr_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic [2:0]        pfunct_code_o,
  input  logic [DATA_W-1:0] prdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;

  logic [1:0]        elig;
  logic              grant_en;
  logic              grant_id;
  logic              done;
  logic              bus_active;

  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        funct_q;

  logic              r0_ack_q, r1_ack_q;
  logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;

  // During its ack cycle a requester still holds req for the finished
  // transaction, so it must not count as a new request.
  assign elig[0]  = r0_req_i & ~r0_ack_q;
  assign elig[1]  = r1_req_i & ~r1_ack_q;
  assign grant_en = (state_q == ST_IDLE) && (elig != 2'b00);

`ifdef OPB_ARB_RR_EN
  logic last_owner_q;

  always_comb begin
    if (elig == 2'b11) grant_id = ~last_owner_q;
    else               grant_id = elig[1] & ~elig[0];
  end

  // Resets to 1 so that r0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i)         last_owner_q <= 1'b1;
    else if (grant_en) last_owner_q <= grant_id;
  end
`else
  assign grant_id = ~elig[0];
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_en) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus_active = 1'b0;
    penable_o  = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_SETUP:  bus_active = 1'b1;
      ST_ACCESS: begin
        bus_active = 1'b1;
        penable_o  = 1'b1;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o        = bus_active;
  assign paddr_o       = bus_active ? addr_q  : '0;
  assign pwrite_o      = bus_active & write_q;
  assign pwdata_o      = (bus_active && write_q) ? wdata_q : '0;
  assign pfunct_code_o = bus_active ? funct_q : 3'd0;

  // Winner's request fields are captured once at grant and held until the
  // next grant, so requester inputs are ignored mid-transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      funct_q <= 3'd0;
    end else if (grant_en) begin
      owner_q <= grant_id;
      if (grant_id) begin
        addr_q  <= r1_addr_i;
        write_q <= r1_write_i;
        wdata_q <= r1_wdata_i;
        funct_q <= r1_funct_i;
      end else begin
        addr_q  <= r0_addr_i;
        write_q <= r0_write_i;
        wdata_q <= r0_wdata_i;
        funct_q <= r0_funct_i;
      end
    end
  end

  // Ack and read data are one-cycle registers; rdata drops back to 0 with
  // the ack so the idle value on both ports is always 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      r0_ack_q   <= done & ~owner_q;
      r1_ack_q   <= done &  owner_q;
      r0_rdata_q <= (done && !owner_q && !write_q) ? prdata_i : '0;
      r1_rdata_q <= (done &&  owner_q && !write_q) ? prdata_i : '0;
    end
  end

  assign r0_ack_o   = r0_ack_q;
  assign r1_ack_o   = r1_ack_q;
  assign r0_rdata_o = r0_rdata_q;
  assign r1_rdata_o = r1_rdata_q;

endmodule

// File: tb/tb_lsu_op_arb.sv
module tb_lsu_op_arb;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              r0_req_i, r1_req_i;
  logic [ADDR_W-1:0] r0_addr_i, r1_addr_i;
  logic              r0_write_i, r1_write_i;
  logic [DATA_W-1:0] r0_wdata_i, r1_wdata_i;
  logic [2:0]        r0_funct_i, r1_funct_i;
  logic              r0_ack_o, r1_ack_o;
  logic [DATA_W-1:0] r0_rdata_o, r1_rdata_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              penable_o, pwrite_o, busy_o;
  logic [DATA_W-1:0] pwdata_o, prdata_i;
  logic [2:0]        pfunct_code_o;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_op_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_req_i(r0_req_i), .r0_addr_i(r0_addr_i), .r0_write_i(r0_write_i),
    .r0_wdata_i(r0_wdata_i), .r0_funct_i(r0_funct_i),
    .r0_ack_o(r0_ack_o), .r0_rdata_o(r0_rdata_o),
    .r1_req_i(r1_req_i), .r1_addr_i(r1_addr_i), .r1_write_i(r1_write_i),
    .r1_wdata_i(r1_wdata_i), .r1_funct_i(r1_funct_i),
    .r1_ack_o(r1_ack_o), .r1_rdata_o(r1_rdata_o),
    .paddr_o(paddr_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pfunct_code_o(pfunct_code_o),
    .prdata_i(prdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Load formatting and store merging done by the peripheral bank.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd2:    return w;
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return {old[31:8], wd[7:0]};
      3'd1, 3'd5: return {old[31:16], wd[15:0]};
      3'd2:       return wd;
      default:    return old;
    endcase
  endfunction

  // Peripheral bank stub
  logic [31:0] bank_mem [64] = '{default: 32'd0};
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = 6'd0;
  logic [31:0] pre_data = 32'd0;

  assign prdata_i = penable_o ? fmt_load(bank_mem[paddr_o], pfunct_code_o) : 32'hDEAD_BEEF;

  always @(posedge clk_i) begin
    if (pre_we)
      bank_mem[pre_addr] <= pre_data;
    else if (penable_o && pwrite_o)
      bank_mem[paddr_o] <= apply_store(bank_mem[paddr_o], pwdata_o, pfunct_code_o);
  end

  logic [31:0] ref_mem [64];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int n, input logic req, input logic [5:0] a, input logic w,
                       input logic [31:0] d, input logic [2:0] f);
    if (n == 0) begin
      r0_req_i = req; r0_addr_i = a; r0_write_i = w; r0_wdata_i = d; r0_funct_i = f;
    end else begin
      r1_req_i = req; r1_addr_i = a; r1_write_i = w; r1_wdata_i = d; r1_funct_i = f;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    drive(1, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [43:0] bus;
    logic [65:0] rsp;
    rst_i = 1'b1;
    drive(0, 1'b1, 6'd5, 1'b1, 32'hFFFF_FFFF, 3'd2);
    drive(1, 1'b1, 6'd6, 1'b1, 32'hFFFF_FFFF, 3'd2);
    tick(); tick(); tick();
    bus = {busy_o, penable_o, pwrite_o, pfunct_code_o, paddr_o, pwdata_o};
    rsp = {r0_ack_o, r1_ack_o, r0_rdata_o, r1_rdata_o};
    n_cmp++;
    if (bus !== 44'd0) begin
      n_bad++; $display("FAIL reset_bus: got %h expected 0", bus);
    end
    n_cmp++;
    if (rsp !== 66'd0) begin
      n_bad++; $display("FAIL reset_rsp: got %h expected 0", rsp);
    end
    do_reset();
    tick();
    bus = {busy_o, penable_o, pwrite_o, pfunct_code_o, paddr_o, pwdata_o};
    n_cmp++;
    if (bus !== 44'd0) begin
      n_bad++; $display("FAIL idle_bus: got %h expected 0", bus);
    end
  endtask

  task automatic test_store_word();
    logic [43:0] bus, exp_bus;
    logic [1:0]  pen_seq [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
    logic [1:0]  got;
    do_reset();
    drive(0, 1'b1, 6'd0, 1'b1, 32'h0000_0079, 3'd2);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) drive(0, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
      if (c == 1) begin
        bus     = {busy_o, penable_o, pwrite_o, pfunct_code_o, paddr_o, pwdata_o};
        exp_bus = {1'b1, 1'b0, 1'b1, 3'd2, 6'd0, 32'h0000_0079};
        n_cmp++;
        if (bus !== exp_bus) begin
          n_bad++; $display("FAIL store_setup_bus: got %h expected %h", bus, exp_bus);
        end
      end
      got = {penable_o, r0_ack_o};
      n_cmp++;
      if (got !== pen_seq[c-1]) begin
        n_bad++; $display("FAIL store_pen_ack T%0d: got %b expected %b", c, got, pen_seq[c-1]);
      end
      if (c == 3) begin
        n_cmp++;
        if (bank_mem[0] !== 32'h0000_0079) begin
          n_bad++; $display("FAIL store_hex0: got %h expected 00000079", bank_mem[0]);
        end
        n_cmp++;
        if (r0_rdata_o !== 32'd0) begin
          n_bad++; $display("FAIL store_rdata: got %h expected 0", r0_rdata_o);
        end
      end
    end
  endtask

  task automatic test_load_byte();
    logic [32:0] r0_side;
    do_reset();
    preload(6'd32, 32'h0000_0080);
    drive(1, 1'b1, 6'd32, 1'b0, 32'h1234_5678, 3'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      r0_side = {r0_ack_o, r0_rdata_o};
      n_cmp++;
      if (r0_side !== 33'd0) begin
        n_bad++; $display("FAIL load_r0_quiet T%0d: got %h expected 0", c, r0_side);
      end
      if (c == 1) begin
        n_cmp++;
        if ({paddr_o, pwrite_o, pwdata_o} !== {6'd32, 1'b0, 32'd0}) begin
          n_bad++; $display("FAIL load_setup: got %h/%b/%h expected 20/0/0", paddr_o, pwrite_o, pwdata_o);
        end
      end
    end
    n_cmp++;
    if ({r1_ack_o, r1_rdata_o} !== {1'b1, 32'hFFFF_FF80}) begin
      n_bad++; $display("FAIL load_byte_ack: got %b %h expected 1 ffffff80", r1_ack_o, r1_rdata_o);
    end
    drive(1, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    tick();
  endtask

  // Both hold req: the owner of each ack is ineligible in its ack cycle, so
  // the other requester is granted then; acks land every 3 cycles.
  task automatic test_back_to_back();
    logic [1:0] got, exp;
    do_reset();
    drive(0, 1'b1, 6'd1, 1'b1, 32'h0000_00A1, 3'd2);
    drive(1, 1'b1, 6'd2, 1'b1, 32'h0000_00B2, 3'd2);
    for (int c = 1; c <= 13; c++) begin
      tick();
      exp = 2'b00;
      if (c % 3 == 0) exp = ((c / 3) % 2 == 1) ? 2'b01 : 2'b10;
      got = {r1_ack_o, r0_ack_o};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL b2b_acks T%0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  // A single held requester becomes eligible again the cycle after its ack.
  task automatic test_hold_through_ack();
    logic got, exp;
    do_reset();
    drive(0, 1'b1, 6'd3, 1'b1, 32'h0000_0033, 3'd2);
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = (c == 3) || (c == 7);
      got = r0_ack_o;
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL hold_ack T%0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_reset_in_access();
    logic [109:0] outs;
    do_reset();
    drive(0, 1'b1, 6'd4, 1'b1, 32'h0000_003F, 3'd2);
    tick();
    tick();
    rst_i = 1'b1;
    n_cmp++;
    if (penable_o !== 1'b1) begin
      n_bad++; $display("FAIL rst_access_pen: got %b expected 1", penable_o);
    end
    tick();
    outs = {busy_o, penable_o, pwrite_o, pfunct_code_o, paddr_o, pwdata_o,
            r0_ack_o, r1_ack_o, r0_rdata_o, r1_rdata_o};
    n_cmp++;
    if (outs !== 110'd0) begin
      n_bad++; $display("FAIL rst_access_outs: got %h expected 0", outs);
    end
    n_cmp++;
    if (bank_mem[4] !== 32'h0000_003F) begin
      n_bad++; $display("FAIL rst_access_hex1: got %h expected 0000003f", bank_mem[4]);
    end
    rst_i = 1'b0;
    drive(0, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    tick();
    n_cmp++;
    if ({busy_o, r0_ack_o} !== 2'b00) begin
      n_bad++; $display("FAIL rst_access_after: got %b expected 00", {busy_o, r0_ack_o});
    end
  endtask

  task automatic test_undef_funct();
    do_reset();
    preload(6'd8, 32'h1234_5678);
    drive(0, 1'b1, 6'd8, 1'b0, 32'd0, 3'd7);
    tick();
    n_cmp++;
    if (pfunct_code_o !== 3'd7) begin
      n_bad++; $display("FAIL undef_passthru: got %0d expected 7", pfunct_code_o);
    end
    tick(); tick();
    n_cmp++;
    if ({r0_ack_o, r0_rdata_o} !== {1'b1, 32'd0}) begin
      n_bad++; $display("FAIL undef_load: got %b %h expected 1 00000000", r0_ack_o, r0_rdata_o);
    end
    drive(0, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    tick();
    drive(0, 1'b1, 6'd8, 1'b1, 32'hFFFF_FFFF, 3'd7);
    tick(); tick(); tick();
    n_cmp++;
    if (r0_ack_o !== 1'b1) begin
      n_bad++; $display("FAIL undef_store_ack: got %b expected 1", r0_ack_o);
    end
    n_cmp++;
    if (bank_mem[8] !== 32'h1234_5678) begin
      n_bad++; $display("FAIL undef_store_mem: got %h expected 12345678", bank_mem[8]);
    end
    drive(0, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    tick();
  endtask

  // Random traffic against a transaction-level model: each grant is a point
  // in time, and the bus, ack and data expectations follow from the number
  // of cycles elapsed since that grant.
  task automatic test_random();
    logic        act [2];
    logic [5:0]  a [2];
    logic        w [2];
    logic [31:0] d [2];
    logic [2:0]  f [2];
    int          ack_cyc [2];
    int          grant_cyc, rel;
    logic        have, own, last, win, el0, el1;
    logic [5:0]  t_addr;
    logic        t_w;
    logic [31:0] t_wd, exp_rd;
    logic [2:0]  t_f;
    logic        e_busy, e_ack0, e_ack1;
    logic [43:0] bus, e_bus;
    logic [32:0] p0, e_p0, p1, e_p1;

    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = bank_mem[i];
    have = 1'b0; last = 1'b1; own = 1'b0; grant_cyc = 0;
    t_addr = 6'd0; t_w = 1'b0; t_wd = 32'd0; t_f = 3'd0; exp_rd = 32'd0;
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; ack_cyc[n] = -10;
      a[n] = 6'd0; w[n] = 1'b0; d[n] = 32'd0; f[n] = 3'd0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (act[n] && ack_cyc[n] == cyc - 1) act[n] = 1'b0;
        if (!act[n] && $urandom_range(0, 2) == 0) begin
          act[n] = 1'b1;
          a[n] = 6'($urandom_range(0, 63));
          w[n] = 1'($urandom_range(0, 1));
          d[n] = $urandom;
          f[n] = 3'($urandom_range(0, 7));
        end
        drive(n, act[n], a[n], w[n], d[n], f[n]);
      end

      rel    = have ? cyc - grant_cyc : 99;
      e_busy = (rel == 1) || (rel == 2);
      e_bus  = {e_busy, rel == 2, e_busy & t_w, e_busy ? t_f : 3'd0,
                e_busy ? t_addr : 6'd0, (e_busy && t_w) ? t_wd : 32'd0};
      e_ack0 = (rel == 3) && !own;
      e_ack1 = (rel == 3) && own;
      e_p0   = {e_ack0, e_ack0 ? exp_rd : 32'd0};
      e_p1   = {e_ack1, e_ack1 ? exp_rd : 32'd0};

      @(negedge clk_i);
      bus = {busy_o, penable_o, pwrite_o, pfunct_code_o, paddr_o, pwdata_o};
      p0  = {r0_ack_o, r0_rdata_o};
      p1  = {r1_ack_o, r1_rdata_o};
      n_cmp++;
      if (bus !== e_bus) begin
        n_bad++; $display("FAIL rnd_bus cyc %0d: got %h expected %h", cyc, bus, e_bus);
      end
      n_cmp++;
      if (p0 !== e_p0) begin
        n_bad++; $display("FAIL rnd_r0 cyc %0d: got %h expected %h", cyc, p0, e_p0);
      end
      n_cmp++;
      if (p1 !== e_p1) begin
        n_bad++; $display("FAIL rnd_r1 cyc %0d: got %h expected %h", cyc, p1, e_p1);
      end

      if (rel == 2) begin
        exp_rd = t_w ? 32'd0 : fmt_load(ref_mem[t_addr], t_f);
        if (t_w) ref_mem[t_addr] = apply_store(ref_mem[t_addr], t_wd, t_f);
      end
      if (rel >= 3) begin
        el0 = act[0] && !e_ack0;
        el1 = act[1] && !e_ack1;
        if (el0 || el1) begin
`ifdef OPB_ARB_RR_EN
          if (el0 && el1) win = !last;
          else            win = el1;
`else
          win = !el0;
`endif
          have = 1'b1; grant_cyc = cyc; own = win; last = win;
          t_addr = a[win]; t_w = w[win]; t_wd = d[win]; t_f = f[win];
          ack_cyc[win] = cyc + 3;
        end
      end
      tick();
    end

    drive(0, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    drive(1, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (bank_mem[i] !== ref_mem[i]) begin
        n_bad++; $display("FAIL rnd_mem[%0d]: got %h expected %h", i, bank_mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    drive(1, 1'b0, 6'd0, 1'b0, 32'd0, 3'd0);
    test_reset();
    test_store_word();
    test_load_byte();
    test_back_to_back();
    test_hold_through_ack();
    test_reset_in_access();
    test_undef_funct();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
